// File: rtl/spi_pkg.sv
// Shared SPI definitions for the display-controller bus initiator and target.
// Mode 0 only: sclk idles low, data launched on falling edge, sampled on rising.
package spi_pkg;
    localparam int   SPI_BITS = 8;
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        TRAIL,
        GAP
    } spi_state_e;
endpackage

// File: rtl/spi_half_period_ctr.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled and pulses tc on the
// last count, then restarts; held at zero while disabled.
module spi_half_period_ctr #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!en || tc)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 MSB-first bus initiator: byte stream in on valid/ready, received
// bytes out as a one-cycle strobe, tx_last releases ss after a trailing phase.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                sclk,
    output logic                ss,
    output logic                mosi,
    input  logic                miso,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                tx_last,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy
);
    localparam int BW = $clog2(SPI_BITS);

    spi_state_e          state, next;
    logic [SPI_BITS-1:0] tx_sh, rx_sh;
    logic [BW-1:0]       bit_cnt;
    logic                last_q;
    logic                ctr_en, tc, accept, byte_end;

    spi_half_period_ctr #(.CLK_DIV(CLK_DIV)) u_ctr (
        .clk (clk),
        .rst (rst),
        .en  (ctr_en),
        .tc  (tc)
    );

    assign accept   = tx_valid && tx_ready;
    assign byte_end = (bit_cnt == BW'(SPI_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next     = state;
        tx_ready = 1'b0;
        ctr_en   = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE, WAIT: begin
                tx_ready = 1'b1;
                if (tx_valid)
                    next = LOW;
            end
            LOW: begin
                ctr_en = 1'b1;
                if (tc)
                    next = HIGH;
            end
            HIGH: begin
                ctr_en = 1'b1;
                if (tc)
                    next = !byte_end ? LOW : (last_q ? TRAIL : WAIT);
            end
            TRAIL: begin
                ctr_en = 1'b1;
                if (tc)
                    next = GAP;
            end
            GAP: begin
                ctr_en = 1'b1;
                if (tc)
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk     <= SPI_CPOL;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                tx_sh  <= tx_data;
                last_q <= tx_last;
                ss     <= 1'b0;
                mosi   <= tx_data[SPI_BITS-1];
            end
            // Sample on the rising edge, launch the next bit on the falling edge.
            if (state == LOW && tc) begin
                sclk  <= ~SPI_CPOL;
                rx_sh <= {rx_sh[SPI_BITS-2:0], miso};
            end
            if (state == HIGH && tc) begin
                sclk    <= SPI_CPOL;
                bit_cnt <= bit_cnt + BW'(1);
                if (byte_end) begin
                    rx_valid <= 1'b1;
                    rx_data  <= rx_sh;
                end else begin
                    tx_sh <= {tx_sh[SPI_BITS-2:0], 1'b0};
                    mosi  <= tx_sh[SPI_BITS-2];
                end
            end
            if (state == TRAIL && tc)
                ss <= 1'b1;
            if (state == GAP && tc)
                mosi <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a D=1 instance with a behavioural mode-0 slave
// on the bus, plus a D=3 instance for divider timing.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic       sclk, ss, mosi, miso, tx_ready, rx_valid, busy, tx_valid, tx_last;
    logic [7:0] tx_data, rx_data;
    logic       sclk3, ss3, mosi3, miso3, tx_ready3, rx_valid3, busy3, tx_valid3, tx_last3;
    logic [7:0] tx_data3, rx_data3;

    spi_master #(.CLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    spi_master #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .sclk(sclk3), .ss(ss3), .mosi(mosi3), .miso(miso3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_last(tx_last3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus monitor and slave model, sampled on the falling clk edge.
    int         ecnt = 0;
    int         nrise = 0;
    int         rxv_double = 0;
    logic       p_sclk = 1'b0, p_ss = 1'b1, p_rxv = 1'b0, first = 1'b1;
    logic [7:0] sreg = 8'h00;
    logic [7:0] miso_pat = 8'hA5;
    int         accq[$], riseq[$], ssrq[$];
    logic [8:0] slvq[$];
    logic [7:0] rxq[$];

    initial begin
        miso = 1'b0;
        forever begin
            @(negedge clk);
            ecnt++;
            if (!rst) begin
                nrise = 0;
                first = 1'b1;
            end else begin
                if (tx_valid && tx_ready) accq.push_back(ecnt + 1);
                if (!ss && p_ss) begin
                    nrise = 0;
                    first = 1'b1;
                end
                if (ss && !p_ss) ssrq.push_back(ecnt);
                if (sclk && !p_sclk) begin
                    riseq.push_back(ecnt);
                    sreg = {sreg[6:0], mosi};
                    nrise++;
                    if (nrise == 8) begin
                        slvq.push_back({first, sreg});
                        first = 1'b0;
                        nrise = 0;
                    end
                end
                if (rx_valid) rxq.push_back(rx_data);
                if (rx_valid && p_rxv) rxv_double++;
            end
            miso   = miso_pat[7 - nrise];
            p_sclk = sclk;
            p_ss   = ss;
            p_rxv  = rx_valid;
        end
    end

    task automatic clear_q();
        accq.delete(); riseq.delete(); ssrq.delete(); slvq.delete(); rxq.delete();
        rxv_double = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        do begin @(negedge clk); k++; end while (!tx_ready && k < 500);
        chk("accept", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 2000);
        chk("idle", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, first_rise, second_rise, first_fall, ss_up, nr, rxj;
        logic [7:0] sb, rxd;
        logic prev, ok;
        tx_valid = 0; tx_data = 0; tx_last = 0;
        tx_valid3 = 0; tx_data3 = 0; tx_last3 = 0; miso3 = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_ss", ss, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx", {rx_valid, rx_data}, 9'h000);
        chk("rst_busy", busy, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // single 0xFF, last
        clear_q();
        send(8'hFF, 1'b1);
        wait_idle();
        chk("a_nbytes", slvq.size(), 1);
        chk("a_slave", slvq[0], {1'b1, 8'hFF});
        chk("a_rise1", riseq[0] - accq[0], 1);
        chk("a_ss_rise", ssrq[0] - accq[0], 17);
        chk("a_rx", rxq[0], 8'hA5);

        // back-to-back 0x00..0x03
        clear_q();
        for (int i = 0; i < 4; i++) send(8'(i), i == 3);
        wait_idle();
        chk("b_nbytes", slvq.size(), 4);
        for (int i = 0; i < 4; i++) chk("b_slave", slvq[i], {i == 0, 8'(i)});
        for (int i = 1; i < 4; i++) chk("b_spacing", accq[i] - accq[i-1], 17);
        chk("b_nrx", rxq.size(), 4);
        chk("b_ss_rise", ssrq.size(), 1);

        // 0x3C out, 0xA5 in
        clear_q();
        send(8'h3C, 1'b1);
        wait_idle();
        chk("c_mosi_bits", slvq[0], {1'b1, 8'h3C});
        chk("c_nrx", rxq.size(), 1);
        chk("c_rx", rxq[0], 8'hA5);
        chk("c_rxv_width", rxv_double, 0);

        // D=3 instance
        tx_data3 = 8'h5A; tx_last3 = 1'b1; tx_valid3 = 1'b1;
        @(negedge clk);
        chk("d3_ready", tx_ready3, 1);
        @(posedge clk); #1;
        tx_valid3 = 1'b0;
        first_rise = -1; second_rise = -1; first_fall = -1; ss_up = -1; rxj = -1;
        nr = 0; sb = 0; rxd = 0; prev = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (sclk3 && !prev) begin
                nr++;
                sb = {sb[6:0], mosi3};
                if (first_rise < 0) first_rise = j;
                else if (second_rise < 0) second_rise = j;
            end
            if (!sclk3 && prev && first_fall < 0) first_fall = j;
            if (ss3 && ss_up < 0) ss_up = j;
            if (rx_valid3) begin rxj = j; rxd = rx_data3; end
            prev = sclk3;
        end
        chk("d3_first_rise", first_rise, 3);
        chk("d3_high_len", first_fall - first_rise, 3);
        chk("d3_low_len", second_rise - first_fall, 3);
        chk("d3_nrise", nr, 8);
        chk("d3_mosi", sb, 8'h5A);
        chk("d3_ss_rise", ss_up, 51);
        chk("d3_rxv_cycle", rxj, 48);
        chk("d3_rx", rxd, 8'hFF);
        chk("d3_busy_end", busy3, 0);
        @(posedge clk); #1;

        // stall between bytes
        clear_q();
        send(8'h11, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (!tx_ready && k < 200);
        chk("s_wait", tx_ready, 1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sclk || ss || !tx_ready) ok = 1'b0;
        end
        chk("s_hold", ok, 1);
        @(posedge clk); #1;
        send(8'h22, 1'b1);
        wait_idle();
        chk("s_rise", riseq[8] - accq[1], 1);
        chk("s_nbytes", slvq.size(), 2);
        chk("s_slave0", slvq[0], {1'b1, 8'h11});
        chk("s_slave1", slvq[1], {1'b0, 8'h22});

        // reset after the 4th rising sclk edge
        clear_q();
        tx_data = 8'h55; tx_last = 1'b1; tx_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!tx_ready && k < 200);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (riseq.size() < 4 && k < 200);
        chk("r_pre_sclk", sclk, 1);
        chk("r_pre_mosi", mosi, 1);
        #1 rst = 1'b0;
        #1;
        chk("r_ss", ss, 1);
        chk("r_sclk", sclk, 0);
        chk("r_mosi", mosi, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("r_no_rxv", rxq.size(), 0);
        chk("r_rx_data", rx_data, 8'h00);
        @(posedge clk); #1;
        send(8'h81, 1'b1);
        wait_idle();
        chk("r_nbytes", slvq.size(), 1);
        chk("r_slave", slvq[0], {1'b1, 8'h81});
        chk("r_rx", rxq[0], 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
